uart_fifo: RTL
==============

Name: uart_fifo

Overview:
- Synchronous first-word-fall-through FIFO that buffers bytes between the UART receiver and the loopback/test consumer, and between that consumer and the UART transmitter.
- Two instances per UART:
  - rx side: written by the receiver's done-tick; read via rd/r_data/empty by the consumer.
  - tx side: written by the consumer via wr/w_data/full; read by the transmitter.
- Single clock domain; registered status flags; adds level reporting and sticky error flags for debug.

Parameters:
- B, 8: data word width in bits.
- W, 4: address width; depth = 2**W entries (16 by default).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  read request; pops the head entry at the clock edge when empty=0.
- wr  in  1  write request; pushes w_data at the clock edge when full=0 (see simultaneous rules).
- w_data  in  B  data to write.
- r_data  out  B  head-of-queue data; combinational from mem[rd_ptr]; valid only while empty=0.
- empty  out  1  registered; 1 when the FIFO holds 0 entries.
- full  out  1  registered; 1 when the FIFO holds 2**W entries.
- level  out  W+1  registered occupancy count, 0 to 2**W.
- ovf  out  1  sticky; set when a write is dropped.
- udf  out  1  sticky; set when a read is requested while empty.

Behaviour:
- Storage and pointers:
  - Storage is mem[0 .. 2**W-1], B bits wide; the memory itself is not reset.
  - wr_ptr and rd_ptr are W bits wide and wrap modulo 2**W.
- Reset (reset=1 at a clk edge):
  - wr_ptr=0, rd_ptr=0, empty=1, full=0, level=0, ovf=0, udf=0.
  - Any rd/wr in that cycle is ignored.
  - Reset mid-operation discards all contents.
- Operation per clock edge, decoded on {wr, rd}:
  - 00: no change.
  - 10 (write only):
    - If full=0: mem[wr_ptr]<=w_data, wr_ptr+1, level+1, empty<=0, full<=(level+1==2**W).
    - If full=1: the write is dropped, ovf<=1, no other state change.
  - 01 (read only):
    - If empty=0: rd_ptr+1, level-1, full<=0, empty<=(level-1==0).
    - If empty=1: udf<=1, no pointer change.
  - 11 (both):
    - If empty=1: perform the write only; empty<=0, level=1; no read-through; udf is not set.
    - If full=1: perform both. r_data this cycle is the old head; the write lands in the slot being freed. full stays 1; level unchanged.
    - Otherwise: both pointers advance; level, empty and full unchanged.
- Latency:
  - The first written word appears on r_data, with empty=0, in the cycle after the write edge.
  - After a pop, r_data shows the next entry immediately after the edge.
- Invariants:
  - empty and full are never both 1.
  - level == (wr_ptr - rd_ptr) mod 2**W, except that level = 2**W when full.
- Sticky flags: ovf and udf are cleared only by reset.

Test Plan:
1. Reset, then write 0x41,0x42,0x43 on consecutive cycles with rd=0 -> empty falls the cycle after the first write; r_data=0x41; level=3; full=0.
2. From state 1, assert rd for 3 cycles -> r_data sequence 0x41,0x42,0x43; empty=1 after the third pop; level=0; udf=0.
3. Write 16 bytes 0x00..0x0F -> full=1 and level=16 after the 16th edge; a 17th write of 0xFF is dropped and ovf=1; then 16 reads return 0x00..0x0F in order and empty=1.
4. Full FIFO, rd=wr=1 with w_data=0xAA -> r_data showed 0x00 before the edge; full stays 1; level=16; after 16 further pops the last value read is 0xAA.
5. Empty FIFO, rd=wr=1 with w_data=0x5A -> next cycle empty=0, r_data=0x5A, level=1, udf=0; then rd alone on an empty FIFO -> udf=1.
6. Fill 20 cycles of alternating write/read through pointer wrap, then assert reset with 5 entries stored -> next cycle empty=1, level=0, ovf=0, udf=0; a following write of 0x33 appears on r_data one cycle later.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through byte FIFO used on both the
// rx and tx sides of the UART. Status flags and the occupancy count are
// registered. The sticky ovf/udf flags record a dropped write or a read
// made while empty; only reset clears them.
//
// Handshake: the FIFO accepts a write on a rising clk edge where wr=1 and
// either full=0, or full=1 with rd=1 (the write then lands in the slot that
// is being freed). It performs a read on a rising clk edge where rd=1 and
// empty=0. r_data shows the head entry combinationally, and it is valid only
// while empty=0. A rejected request changes no data state. It only sets the
// matching sticky flag. A read and write together on an empty FIFO
// performs only the write and is not an underflow.
module uart_fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   level,
  output logic         ovf,
  output logic         udf
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);

  logic [B-1:0] mem [0:2**W-1];
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_ptr;

  logic         do_wr;
  logic         do_rd;
  logic [W:0]   level_next;

  // Accept or reject each request, and work out the occupancy after this edge
  always_comb begin
    do_wr      = wr & (~full | rd);
    do_rd      = rd & ~empty;
    level_next = level;
    case ({do_wr, do_rd})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // Storage array, written only on an accepted write and never reset
  always_ff @(posedge clk) begin
    if (!reset && do_wr)
      mem[wr_ptr] <= w_data;
  end

  // Pointers, registered flags, occupancy and sticky error bits
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      empty <= (level_next == '0);
      full  <= (level_next == DEPTH);
      if (wr && full && !rd) ovf <= 1'b1;
      if (rd && empty && !wr) udf <= 1'b1;
    end
  end

  // First-word-fall-through head-of-queue output
  assign r_data = mem[rd_ptr];

endmodule
